mor1kx_rf_wrport_cappuccino: RTL

Write-side front end of the cappuccino register file. It arbitrates the single RF write port among three result producers: the single-cycle ALU result from ctrl, load data from the LSU, and the multi-cycle mul/div unit. It drives the registered `wb_rf_wb`/`wb_rfd_adr`/`result` triple that the RF RAMs and bypass logic consume. It also keeps a scoreboard of destination GPRs with outstanding long-latency writes, so decode can stall on them.

---
 rtl/mor1kx_rf_wrport_cappuccino_pkg.sv | 38 +++
 rtl/mor1kx_rf_scoreboard.sv | 44 ++++
 rtl/mor1kx_rf_wrport_cappuccino.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mor1kx_rf_wrport_cappuccino_pkg.sv
// Shared encodings for the cappuccino RF write-port front end: write-source
// identifiers, the default starvation limit and the grant priority function.
package mor1kx_rf_wrport_cappuccino_pkg;

    typedef enum logic [1:0] {
        RF_WSRC_NONE = 2'd0,
        RF_WSRC_ALU  = 2'd1,
        RF_WSRC_LSU  = 2'd2,
        RF_WSRC_MD   = 2'd3
    } rf_wsrc_e;

    localparam int RF_STARVE_LIMIT_DEFAULT = 4;

    // While the ALU is stalled the port is lent out, and mul/div goes first
    // because it is the producer most likely to have been waiting longest.
    function automatic rf_wsrc_e rf_wsrc_pick(input logic alu_req,
                                              input logic lsu_req,
                                              input logic md_req,
                                              input logic alu_stall);
        rf_wsrc_e src;
        src = RF_WSRC_NONE;
        if (alu_stall) begin
            if (md_req)
                src = RF_WSRC_MD;
            else if (lsu_req)
                src = RF_WSRC_LSU;
        end else begin
            if (alu_req)
                src = RF_WSRC_ALU;
            else if (lsu_req)
                src = RF_WSRC_LSU;
            else if (md_req)
                src = RF_WSRC_MD;
        end
        return src;
    endfunction

endpackage

// File: rtl/mor1kx_rf_scoreboard.sv
// Busy bitmap of GPRs with an outstanding long-latency write. Sets come from
// issue, clears from write-back transfers; a set beats a clear to the same GPR.
module mor1kx_rf_scoreboard #(
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int OPTION_RF_WORDS      = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            set_a,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] set_a_adr,
    input  logic                            set_b,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] set_b_adr,
    input  logic                            clr_a,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] clr_a_adr,
    input  logic                            clr_b,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] clr_b_adr,
    output logic [OPTION_RF_WORDS-1:0]      busy_o
);

    logic [OPTION_RF_WORDS-1:0] set_vec;
    logic [OPTION_RF_WORDS-1:0] clr_vec;

    // r0 is hardwired, so it never becomes busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_a && set_a_adr != '0)
            set_vec[set_a_adr] = 1'b1;
        if (set_b && set_b_adr != '0)
            set_vec[set_b_adr] = 1'b1;
        if (clr_a)
            clr_vec[clr_a_adr] = 1'b1;
        if (clr_b)
            clr_vec[clr_b_adr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_o <= '0;
        else
            busy_o <= (busy_o & ~clr_vec) | set_vec;
    end

endmodule

// File: rtl/mor1kx_rf_wrport_cappuccino.sv
// Cappuccino RF write-port arbiter: ALU / LSU / mul-div share one registered
// write port, with a starvation counter that briefly stalls the ALU.
module mor1kx_rf_wrport_cappuccino
    import mor1kx_rf_wrport_cappuccino_pkg::*;
#(
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int OPTION_RF_WORDS      = 32,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int STARVE_LIMIT         = RF_STARVE_LIMIT_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  pipeline_flush_i,
    input  logic                                  alu_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]       alu_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]       alu_result_i,
    input  logic                                  lsu_valid_i,
    output logic                                  lsu_ready_o,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]       lsu_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]       lsu_result_i,
    input  logic                                  md_valid_i,
    output logic                                  md_ready_o,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]       md_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]       md_result_i,
    input  logic                                  lsu_issue_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]       lsu_issue_adr_i,
    input  logic                                  md_issue_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]       md_issue_adr_i,
    output logic                                  alu_stall_o,
    output logic                                  wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]       wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]       wb_result_o,
    output logic [OPTION_RF_WORDS-1:0]            busy_o,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]     wait_cnt_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    // Handshake: a producer raises valid and holds address/data stable until
    // ready; ready is the combinational grant, and valid & ready is a transfer.
    rf_wsrc_e                          gnt;
    logic [OPTION_RF_ADDR_WIDTH-1:0]   gnt_adr;
    logic [OPTION_OPERAND_WIDTH-1:0]   gnt_data;
    logic                              lsu_xfer;
    logic                              md_xfer;
    logic                              blocked;
    logic [CNT_W-1:0]                  wait_cnt;

    always_comb begin
        gnt      = RF_WSRC_NONE;
        gnt_adr  = '0;
        gnt_data = '0;
        if (rst_n)
            gnt = rf_wsrc_pick(alu_wb_i & ~pipeline_flush_i, lsu_valid_i,
                               md_valid_i, alu_stall_o);
        case (gnt)
            RF_WSRC_ALU: begin
                gnt_adr  = alu_rfd_adr_i;
                gnt_data = alu_result_i;
            end
            RF_WSRC_LSU: begin
                gnt_adr  = lsu_rfd_adr_i;
                gnt_data = lsu_result_i;
            end
            RF_WSRC_MD: begin
                gnt_adr  = md_rfd_adr_i;
                gnt_data = md_result_i;
            end
            default: ;
        endcase
    end

    assign lsu_ready_o = (gnt == RF_WSRC_LSU);
    assign md_ready_o  = (gnt == RF_WSRC_MD);
    assign lsu_xfer    = lsu_valid_i & lsu_ready_o;
    assign md_xfer     = md_valid_i & md_ready_o;
    assign blocked     = (lsu_valid_i & ~lsu_ready_o) | (md_valid_i & ~md_ready_o);
    assign wait_cnt_o  = wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_rf_wb_o   <= 1'b0;
            wb_rfd_adr_o <= '0;
            wb_result_o  <= '0;
            wait_cnt     <= '0;
            alu_stall_o  <= 1'b0;
        end else begin
            // r0 writes complete the handshake but never reach the RAMs.
            wb_rf_wb_o <= (gnt != RF_WSRC_NONE) && (gnt_adr != '0);
            if (gnt != RF_WSRC_NONE) begin
                wb_rfd_adr_o <= gnt_adr;
                wb_result_o  <= gnt_data;
            end
            if (lsu_xfer || md_xfer)
                wait_cnt <= '0;
            else if (blocked && wait_cnt != CNT_W'(STARVE_LIMIT))
                wait_cnt <= wait_cnt + 1'b1;
            // One-cycle loan of the port; the !alu_stall_o term forbids a repeat.
            alu_stall_o <= (wait_cnt == CNT_W'(STARVE_LIMIT - 1)) && blocked &&
                           !alu_stall_o;
        end
    end

    mor1kx_rf_scoreboard #(
        .OPTION_RF_ADDR_WIDTH(OPTION_RF_ADDR_WIDTH),
        .OPTION_RF_WORDS     (OPTION_RF_WORDS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_a    (lsu_issue_i & rst_n),
        .set_a_adr(lsu_issue_adr_i),
        .set_b    (md_issue_i & rst_n),
        .set_b_adr(md_issue_adr_i),
        .clr_a    (lsu_xfer),
        .clr_a_adr(lsu_rfd_adr_i),
        .clr_b    (md_xfer),
        .clr_b_adr(md_rfd_adr_i),
        .busy_o   (busy_o)
    );

endmodule
